// File: rtl/riscv_defs.sv
// Shared CSR-stage definitions: exception codes, trap-redirect FSM encoding, event decode.
// Pure declarations, no latency.
// No handshake of its own.
package riscv_defs;

    localparam int EXCEPTION_W = 5;

    localparam logic [EXCEPTION_W-1:0] EXCEPTION_NONE  = 5'd0;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE = 5'd1;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FPU   = 5'd2;

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_DRAIN    = 2'd1;
    localparam logic [1:0] STATE_INVAL    = 2'd2;
    localparam logic [1:0] STATE_REDIRECT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = STATE_IDLE,
        ST_DRAIN    = STATE_DRAIN,
        ST_INVAL    = STATE_INVAL,
        ST_REDIRECT = STATE_REDIRECT
    } trap_state_e;

    localparam int DRAIN_CNT_W = 4;

    // FPU status codes ride along without a branch and are purely informational.
    function automatic logic is_trap_event(input logic                   valid,
                                           input logic                   branch,
                                           input logic [EXCEPTION_W-1:0] code);
        return valid && (branch || (code == EXCEPTION_FENCE));
    endfunction

endpackage

// File: rtl/csr_trap_drain_cnt.sv
// Loadable down-counter with zero flag, sets the flush drain window.
// zero_o reflects the registered count; load wins over decrement.
// Decrement saturates at zero, no backpressure.
module csr_trap_drain_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/csr_trap_redirect.sv
// CSR trap/FENCE.I sequencer: flush, optional I-cache invalidate, PC redirect; CSR_TRAP_PERF_EN adds counters.
// Latency: event at N -> flush N+1..N+DRAIN_CYCLES, redirect from N+DRAIN_CYCLES+1 (+inval wait).
// Backpressure: busy_o stalls upstream until fetch_ready_i accepts the held redirect.
module csr_trap_redirect
    import riscv_defs::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   evt_valid_i,
    input  logic [EXCEPTION_W-1:0] exception_i,
    input  logic                   csr_branch_i,
    input  logic [31:0]            csr_target_i,
    input  logic [31:0]            exception_pc_i,
    input  logic                   fetch_ready_i,
    input  logic                   icache_inv_done_i,
    output logic                   flush_o,
    output logic                   icache_inv_o,
    output logic                   redirect_valid_o,
    output logic [31:0]            redirect_pc_o,
    output logic                   busy_o
`ifdef CSR_TRAP_PERF_EN
    ,
    output logic [31:0]            trap_count_o,
    output logic [15:0]            fence_count_o
`endif
);

    trap_state_e state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        fence_q, fence_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        take_evt;
    logic        drain_zero;

    assign take_evt = (state_q == ST_IDLE) &&
                      is_trap_event(evt_valid_i, csr_branch_i, exception_i);

    csr_trap_drain_cnt #(
        .W (DRAIN_CNT_W)
    ) u_drain_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (take_evt),
        .load_val_i (DRAIN_CNT_W'(DRAIN_CYCLES - 1)),
        .dec_i      (state_q == ST_DRAIN),
        .zero_o     (drain_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take_evt)          state_d = ST_DRAIN;
            ST_DRAIN:    if (drain_zero)        state_d = fence_q ? ST_INVAL : ST_REDIRECT;
            ST_INVAL:    if (icache_inv_done_i) state_d = ST_REDIRECT;
            ST_REDIRECT: if (fetch_ready_i)     state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Target is captured once at the taking edge; the offered PC is latched on REDIRECT entry
    // so it stays frozen through backpressure and persists afterwards in IDLE.
    always_comb begin
        target_d      = target_q;
        fence_d       = fence_q;
        redirect_pc_d = redirect_pc_q;
        if (take_evt) begin
            target_d = csr_branch_i ? csr_target_i : (exception_pc_i + 32'd4);
            fence_d  = (exception_i == EXCEPTION_FENCE);
        end
        if ((state_d == ST_REDIRECT) && (state_q != ST_REDIRECT)) begin
            redirect_pc_d = target_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q      <= '0;
            fence_q       <= 1'b0;
            redirect_pc_q <= RESET_PC;
        end else begin
            target_q      <= target_d;
            fence_q       <= fence_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        flush_o          = 1'b0;
        icache_inv_o     = 1'b0;
        redirect_valid_o = 1'b0;
        busy_o           = 1'b0;
        case (state_q)
            ST_DRAIN:    begin flush_o          = 1'b1; busy_o = 1'b1; end
            ST_INVAL:    begin icache_inv_o     = 1'b1; busy_o = 1'b1; end
            ST_REDIRECT: begin redirect_valid_o = 1'b1; busy_o = 1'b1; end
            default:     ;
        endcase
    end

    assign redirect_pc_o = redirect_pc_q;

`ifdef CSR_TRAP_PERF_EN
    logic [31:0] trap_count_q, trap_count_d;
    logic [15:0] fence_count_q, fence_count_d;

    always_comb begin
        trap_count_d  = trap_count_q;
        fence_count_d = fence_count_q;
        if ((state_q == ST_REDIRECT) && fetch_ready_i) begin
            trap_count_d = trap_count_q + 32'd1;
        end
        if ((state_q == ST_INVAL) && icache_inv_done_i) begin
            fence_count_d = fence_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_count_q  <= '0;
            fence_count_q <= '0;
        end else begin
            trap_count_q  <= trap_count_d;
            fence_count_q <= fence_count_d;
        end
    end

    assign trap_count_o  = trap_count_q;
    assign fence_count_o = fence_count_q;
`endif

    // A non-FPU, non-FENCE code without a branch means the CSR file lost a trap.
    a_no_orphan_exception: assert property (@(posedge clk) disable iff (!rst_n)
        !(evt_valid_i && !csr_branch_i && (exception_i != EXCEPTION_NONE) &&
          (exception_i != EXCEPTION_FENCE) && (exception_i != EXCEPTION_FPU)));

endmodule

// File: tb/tb_csr_trap_redirect.sv
// Bench for csr_trap_redirect: per-cycle timeline model of each trap sequence.
module tb_csr_trap_redirect;
    import riscv_defs::*;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_1000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   evt_valid;
    logic [EXCEPTION_W-1:0] exc;
    logic                   br;
    logic [31:0]            tgt;
    logic [31:0]            epc;
    logic                   fetch_ready;
    logic                   inv_done;
    logic                   flush;
    logic                   inv;
    logic                   rv;
    logic [31:0]            rpc;
    logic                   busy;
`ifdef CSR_TRAP_PERF_EN
    logic [31:0]            trap_count;
    logic [15:0]            fence_count;
`endif

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] prev_pc;

    csr_trap_redirect #(
        .DRAIN_CYCLES (D),
        .RESET_PC     (RPC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .evt_valid_i       (evt_valid),
        .exception_i       (exc),
        .csr_branch_i      (br),
        .csr_target_i      (tgt),
        .exception_pc_i    (epc),
        .fetch_ready_i     (fetch_ready),
        .icache_inv_done_i (inv_done),
        .flush_o           (flush),
        .icache_inv_o      (inv),
        .redirect_valid_o  (rv),
        .redirect_pc_o     (rpc),
        .busy_o            (busy)
`ifdef CSR_TRAP_PERF_EN
        ,
        .trap_count_o      (trap_count),
        .fence_count_o     (fence_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic drive_idle();
        evt_valid   = 1'b0;
        exc         = EXCEPTION_NONE;
        br          = 1'b0;
        tgt         = '0;
        epc         = '0;
        fetch_ready = 1'b0;
        inv_done    = 1'b0;
    endtask

    // Drives one event now (at a negedge) and checks every cycle until the cycle after handshake.
    task automatic run_event(input logic br_in, input logic [EXCEPTION_W-1:0] exc_in,
                             input logic [31:0] tgt_in, input logic [31:0] pc_in,
                             input int inv_lat, input int rdy_lat, input bit offer2,
                             input string name);
        logic        is_fence;
        logic [31:0] exp_tgt;
        logic [31:0] exp_pc;
        logic [3:0]  exp_v;
        logic [3:0]  got_v;
        int          red_start;
        int          red_end;
        is_fence  = (exc_in == EXCEPTION_FENCE);
        exp_tgt   = br_in ? tgt_in : (pc_in + 32'd4);
        red_start = D + 1 + (is_fence ? inv_lat : 0);
        red_end   = red_start + rdy_lat;
        evt_valid   = 1'b1;
        br          = br_in;
        exc         = exc_in;
        tgt         = tgt_in;
        epc         = pc_in;
        fetch_ready = (rdy_lat == 0);
        inv_done    = 1'b0;
        for (int k = 1; k <= red_end + 1; k++) begin
            @(negedge clk);
            exp_v = {(k <= D),
                     (is_fence && (k > D) && (k <= D + inv_lat)),
                     ((k >= red_start) && (k <= red_end)),
                     (k <= red_end)};
            got_v  = {flush, inv, rv, busy};
            exp_pc = (k >= red_start) ? exp_tgt : prev_pc;
            compared++;
            if (got_v !== exp_v) begin
                mismatched++;
                $display("FAIL %s cycle %0d flush/inv/rv/busy: got %b expected %b", name, k, got_v, exp_v);
            end
            compared++;
            if (rpc !== exp_pc) begin
                mismatched++;
                $display("FAIL %s cycle %0d redirect_pc: got %h expected %h", name, k, rpc, exp_pc);
            end
            if (k == red_end + 1) begin
                drive_idle();
            end else begin
                evt_valid   = offer2 && (k == 2);
                br          = offer2 && (k == 2);
                exc         = (offer2 && (k == 2)) ? EXCEPTION_FENCE : EXCEPTION_NONE;
                tgt         = $urandom;
                epc         = $urandom;
                fetch_ready = (rdy_lat == 0) || (k >= red_end);
                inv_done    = is_fence ? (k == D + inv_lat) : ((k == 1) && ($urandom_range(0, 1) == 1));
            end
        end
        prev_pc = exp_tgt;
    endtask

    task automatic test_reset();
        compared++;
        if ({flush, inv, rv, busy} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset outputs: got %b expected 0000", {flush, inv, rv, busy});
        end
        compared++;
        if (rpc !== RPC) begin
            mismatched++;
            $display("FAIL reset redirect_pc: got %h expected %h", rpc, RPC);
        end
    endtask

    task automatic test_trap_entry();
        run_event(1'b1, EXCEPTION_NONE, 32'h8000_0100, $urandom, 1, 0, 1'b0, "trap_entry");
    endtask

    task automatic test_fence();
        run_event(1'b0, EXCEPTION_FENCE, $urandom, 32'h0000_2000, 5, 0, 1'b0, "fence");
    endtask

    task automatic test_backpressure();
        run_event(1'b1, EXCEPTION_FPU, 32'h1234_5678, $urandom, 1, 7, 1'b1, "backpressure");
    endtask

    task automatic test_wrap();
        run_event(1'b0, EXCEPTION_FENCE, $urandom, 32'hFFFF_FFFC, 1, 0, 1'b0, "wrap");
    endtask

    task automatic test_fence_branch();
        run_event(1'b1, EXCEPTION_FENCE, 32'hC0DE_0040, 32'h0000_3000, 3, 2, 1'b0, "fence_branch");
    endtask

    task automatic test_no_event();
        evt_valid = 1'b1;
        exc       = EXCEPTION_FPU;
        br        = 1'b0;
        epc       = $urandom;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            compared++;
            if ({flush, inv, rv, busy} !== 4'b0000) begin
                mismatched++;
                $display("FAIL no_event cycle %0d outputs: got %b expected 0000", k, {flush, inv, rv, busy});
            end
            compared++;
            if (rpc !== prev_pc) begin
                mismatched++;
                $display("FAIL no_event cycle %0d redirect_pc: got %h expected %h", k, rpc, prev_pc);
            end
            drive_idle();
            if (k == 1) begin
                evt_valid = 1'b1;
            end else if (k == 2) begin
                br       = 1'b1;
                tgt      = $urandom;
                inv_done = 1'b1;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_event(1'b1, EXCEPTION_NONE, $urandom, $urandom, 1, i, 1'b0, "back_to_back");
        end
    endtask

    task automatic test_random();
        logic                   r_br;
        logic [EXCEPTION_W-1:0] r_exc;
        for (int i = 0; i < 20; i++) begin
            r_br = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       r_exc = EXCEPTION_NONE;
                1:       r_exc = EXCEPTION_FENCE;
                default: r_exc = EXCEPTION_FPU;
            endcase
            if (!r_br) r_exc = EXCEPTION_FENCE;
            run_event(r_br, r_exc, $urandom, $urandom, $urandom_range(1, 6), $urandom_range(0, 5),
                      ($urandom_range(0, 1) == 1), "random");
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_inval();
        evt_valid = 1'b1;
        exc       = EXCEPTION_FENCE;
        br        = 1'b0;
        epc       = $urandom;
        for (int k = 1; k <= D + 2; k++) begin
            @(negedge clk);
            drive_idle();
        end
        compared++;
        if (inv !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mid_inval pre-reset icache_inv: got %b expected 1", inv);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({flush, inv, rv, busy} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_mid_inval async outputs: got %b expected 0000", {flush, inv, rv, busy});
        end
        compared++;
        if (rpc !== RPC) begin
            mismatched++;
            $display("FAIL reset_mid_inval async redirect_pc: got %h expected %h", rpc, RPC);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        inv_done = 1'b1;
        fetch_ready = 1'b1;
        prev_pc  = RPC;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            inv_done = 1'b0;
            compared++;
            if (({flush, inv, rv, busy} !== 4'b0000) || (rpc !== RPC)) begin
                mismatched++;
                $display("FAIL reset_mid_inval after cycle %0d: got %b/%h expected 0000/%h",
                         k, {flush, inv, rv, busy}, rpc, RPC);
            end
        end
        drive_idle();
    endtask

`ifdef CSR_TRAP_PERF_EN
    task automatic test_perf();
        for (int i = 0; i < 3; i++) begin
            run_event(1'b1, EXCEPTION_NONE, $urandom, $urandom, 1, $urandom_range(0, 2), 1'b0, "perf_trap");
        end
        run_event(1'b0, EXCEPTION_FENCE, $urandom, $urandom, 2, 1, 1'b0, "perf_fence");
        compared++;
        if (trap_count !== 32'd4) begin
            mismatched++;
            $display("FAIL perf trap_count: got %0d expected 4", trap_count);
        end
        compared++;
        if (fence_count !== 16'd1) begin
            mismatched++;
            $display("FAIL perf fence_count: got %0d expected 1", fence_count);
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        prev_pc = RPC;
        drive_idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_trap_entry();
        test_fence();
        test_backpressure();
        test_wrap();
        test_fence_branch();
        test_no_event();
        test_back_to_back();
        test_random();
        test_reset_mid_inval();
`ifdef CSR_TRAP_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/csr_trap_redirect.md
Name: csr_trap_redirect

Overview:
- Sits directly downstream of the CSR execute stage.
- Consumes its per-instruction exception code, CSR branch request and branch target.
- Sequences the resulting pipeline flush, optional I-cache invalidate (FENCE.I) and front-end PC redirect.
- Holds the upstream pipe via busy_o until the fetch unit accepts the new PC.

Parameters:
- DRAIN_CYCLES, 2, cycles flush_o is held before any redirect; legal range 1..15.
- RESET_PC, 32'h0000_0000, value of redirect_pc_o out of reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- evt_valid_i  in  1  CSR-stage instruction retiring this cycle; qualifies the other evt inputs
- exception_i  in  EXCEPTION_W  exception code from CSR stage; 0 = none
- csr_branch_i  in  1  CSR file requests control transfer (trap entry / ERET)
- csr_target_i  in  32  target PC for csr_branch_i
- exception_pc_i  in  32  PC of the retiring instruction
- fetch_ready_i  in  1  fetch accepts redirect
- icache_inv_done_i  in  1  I-cache invalidate complete (single-cycle pulse or level)
- flush_o  out  1  kill younger instructions in the pipe
- icache_inv_o  out  1  I-cache invalidate request, level
- redirect_valid_o  out  1  new PC offered to fetch
- redirect_pc_o  out  32  new PC
- busy_o  out  1  block is not IDLE; upstream must stall

Behaviour:
- Reset: clk is the sole clock. rst_n is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0 except redirect_pc_o = RESET_PC; drain counter 0.
- Event detection: an event is taken in IDLE only, when evt_valid_i && (csr_branch_i || exception_i == EXCEPTION_FENCE).
  - exception_i == EXCEPTION_FPU with no csr_branch_i is informational → no event.
  - Any other nonzero code without csr_branch_i → no event. That is a CSR-file bug; assertion only.
- Capture on the taking edge:
  - target = csr_branch_i ? csr_target_i : exception_pc_i + 32'd4, with 32-bit wrap (0xFFFF_FFFC+4 = 0).
  - is_fence = (exception_i == EXCEPTION_FENCE).
- FSM (registered outputs, all decoded from state):
  - IDLE: event taken → DRAIN, counter = DRAIN_CYCLES-1.
  - DRAIN: flush_o=1, busy_o=1. Counter 0 → (is_fence ? INVAL : REDIRECT); otherwise decrement.
  - INVAL: icache_inv_o=1, busy_o=1. icache_inv_done_i → REDIRECT, and icache_inv_o drops the next cycle.
  - REDIRECT: redirect_valid_o=1, redirect_pc_o=target, busy_o=1. redirect_valid_o, redirect_pc_o and target are stable until fetch_ready_i. fetch_ready_i → IDLE.
- Latency:
  - Event cycle N → flush_o high cycles N+1..N+DRAIN_CYCLES.
  - redirect_valid_o first high at N+DRAIN_CYCLES+1 (non-fence, no inval wait).
  - Back-to-back: a new event is accepted the cycle after the fetch_ready_i handshake.
- Boundaries:
  - Events while busy_o=1 are ignored; upstream guarantees none via stall.
  - fetch_ready_i high before REDIRECT has no effect.
  - icache_inv_done_i outside INVAL is ignored.
  - fetch_ready_i held permanently high completes REDIRECT in exactly one cycle.
  - Fence plus csr_branch_i in the same cycle: invalidate is still performed; target = csr_target_i.
  - rst_n asserted mid-sequence: immediate return to reset values. A pending redirect is dropped.
- redirect_pc_o keeps its last value in IDLE.

Optional Feature:
- Macro: CSR_TRAP_PERF_EN.
- Defined:
  - Adds output trap_count_o [31:0], reset 0.
  - Increments by 1 on every REDIRECT→IDLE handshake, wrapping 0xFFFF_FFFF→0.
  - Adds output fence_count_o [15:0], incremented on INVAL exit, wrapping.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package (riscv_defs): EXCEPTION_W, EXCEPTION_FENCE and EXCEPTION_FPU codes, and the FSM state encoding localparams (IDLE=0, DRAIN=1, INVAL=2, REDIRECT=3).
- One natural sub-module: csr_trap_drain_cnt, a loadable down-counter with a zero flag. Everything else stays flat.

Test Plan:
- Trap entry (DRAIN_CYCLES=2): evt_valid_i=1, csr_branch_i=1, csr_target_i=32'h8000_0100 at cycle 10, fetch_ready_i=1 → flush_o high cycles 11-12; redirect_valid_o=1 with pc 32'h8000_0100 at cycle 13; busy_o low at 14.
- FENCE.I: exception_i=EXCEPTION_FENCE, exception_pc_i=32'h0000_2000, icache_inv_done_i pulsed 5 cycles after INVAL entry → icache_inv_o held 5 cycles; redirect_pc_o=32'h0000_2004.
- Backpressure: fetch_ready_i low for 7 cycles in REDIRECT → redirect_valid_o and pc stable all 7 cycles; exactly one handshake; a second event offered while busy is ignored.
- Wrap and no-event cases:
  - FENCE at exception_pc_i=32'hFFFF_FFFC → redirect_pc_o=32'h0.
  - exception_i=EXCEPTION_FPU alone → no flush, busy_o stays 0.
- Reset mid-INVAL: deassert then reassert rst_n → all outputs 0, redirect_pc_o=RESET_PC. A later icache_inv_done_i produces no redirect.
- With CSR_TRAP_PERF_EN: 3 traps + 1 fence → trap_count_o=4, fence_count_o=1. Preload 32'hFFFF_FFFF then one trap → trap_count_o=0.
